// File: rtl/rf_pkg.sv
// Shared widths, limits, arbiter state encoding and a decode helper for the
// register-file write arbiter and its multicycle result FIFO.
package rf_pkg;

    localparam int REG_AW        = 5;
    localparam int DATA_W        = 32;
    localparam int MD_FIFO_DEPTH = 2;
    localparam int STARVE_LIMIT  = 3;

    localparam int NUM_REGS = 1 << REG_AW;
    localparam int CNT_W    = $clog2(MD_FIFO_DEPTH + 1);
    localparam int PTR_W    = (MD_FIFO_DEPTH > 1) ? $clog2(MD_FIFO_DEPTH) : 1;
    localparam int WAIT_W   = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        STARVE = 2'd2
    } arb_state_t;

    // One-hot decode of a register address into a scoreboard mask.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] wa);
        logic [NUM_REGS-1:0] m;
        m     = '0;
        m[wa] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/md_result_fifo.sv
// Small circular buffer holding mul/div results (destination + data) until
// the arbiter finds a free slot on the register-file write port.
module md_result_fifo
    import rf_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [REG_AW-1:0] push_wa,
    input  logic [DATA_W-1:0] push_wd,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic [REG_AW-1:0] head_wa,
    output logic [DATA_W-1:0] head_wd
);

    logic [REG_AW-1:0] mem_wa [MD_FIFO_DEPTH];
    logic [DATA_W-1:0] mem_wd [MD_FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(MD_FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head_wa = mem_wa[rd_ptr];
    assign head_wd = mem_wd[rd_ptr];

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_wa[wr_ptr] <= push_wa;
            mem_wd[wr_ptr] <= push_wd;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop may coincide at any fill level.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(MD_FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(MD_FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the single register-file write port between the pipeline writeback
// stage and buffered mul/div results, tracks pending destinations in a
// scoreboard, and asks the hazard unit for a WB bubble when a result starves.
module rf_write_arbiter
    import rf_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                wb_we,
    input  logic [REG_AW-1:0]   wb_wa,
    input  logic [DATA_W-1:0]   wb_wd,
    input  logic                md_valid,
    input  logic [REG_AW-1:0]   md_wa,
    input  logic [DATA_W-1:0]   md_wd,
    output logic                md_ready,
    input  logic                issue_valid,
    input  logic [REG_AW-1:0]   issue_wa,
    output logic                rf_we,
    output logic [REG_AW-1:0]   rf_wa,
    output logic [DATA_W-1:0]   rf_wd,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                wb_stall
);

    localparam logic [WAIT_W-1:0] WAIT_MAX   = '1;
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(STARVE_LIMIT - 1);

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [REG_AW-1:0] head_wa;
    logic [DATA_W-1:0] head_wd;

    logic              wb_grant;
    logic              fifo_grant;
    logic              head_denied;
    logic [CNT_W-1:0]  occ_next;

    arb_state_t          state;
    arb_state_t          state_next;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W-1:0]   wait_cnt_next;
    logic [NUM_REGS-1:0] busy_next;

    md_result_fifo u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .push_wa (md_wa),
        .push_wd (md_wd),
        .pop     (fifo_pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count),
        .head_wa (head_wa),
        .head_wd (head_wd)
    );

    // md_ready depends only on registered occupancy, never on md_valid.
    assign md_ready    = !fifo_full;
    assign fifo_push   = md_valid && md_ready && !reset;
    assign fifo_pop    = fifo_grant;
    assign head_denied = wb_grant && !fifo_empty;
    assign wb_stall    = (state == STARVE);

    // Port grant: a real WB write wins, otherwise the FIFO head drains; r0 targets never write.
    always_comb begin
        wb_grant   = 1'b0;
        fifo_grant = 1'b0;
        rf_we      = 1'b0;
        rf_wa      = '0;
        rf_wd      = '0;
        if (!reset) begin
            wb_grant   = wb_we && (wb_wa != '0);
            fifo_grant = !wb_grant && !fifo_empty;
        end
        if (wb_grant) begin
            rf_we = 1'b1;
            rf_wa = wb_wa;
            rf_wd = wb_wd;
        end else if (fifo_grant && (head_wa != '0)) begin
            rf_we = 1'b1;
            rf_wa = head_wa;
            rf_wd = head_wd;
        end
    end

    // Next state and head-wait counter derived from push/pop/denial activity.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        occ_next      = fifo_count;
        if (fifo_push) begin
            occ_next = occ_next + CNT_W'(1);
        end
        if (fifo_pop) begin
            occ_next = occ_next - CNT_W'(1);
        end
        if (fifo_pop) begin
            wait_cnt_next = '0;
        end else if (head_denied && (wait_cnt != WAIT_MAX)) begin
            wait_cnt_next = wait_cnt + WAIT_W'(1);
        end
        unique case (state)
            IDLE: begin
                if (fifo_push) begin
                    state_next = PEND;
                end
            end
            PEND: begin
                if (fifo_pop && (occ_next == '0)) begin
                    state_next = IDLE;
                end else if (head_denied && (wait_cnt == WAIT_LAST)) begin
                    state_next = STARVE;
                end
            end
            STARVE: begin
                if (fifo_pop) begin
                    state_next = (occ_next == '0) ? IDLE : PEND;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Scoreboard update: FIFO pops clear, issues set, set wins on collision, r0 never busy.
    always_comb begin
        busy_next = busy_mask;
        if (fifo_pop) begin
            busy_next = busy_next & ~reg_onehot(head_wa);
        end
        if (issue_valid && (issue_wa != '0)) begin
            busy_next = busy_next | reg_onehot(issue_wa);
        end
        busy_next[0] = 1'b0;
    end

    // State, counter and scoreboard registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            busy_mask <= '0;
        end else begin
            state     <= state_next;
            wait_cnt  <= wait_cnt_next;
            busy_mask <= busy_next;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: a directed vector table, a reset-while-full
// sequence, and randomized traffic against a queue-based reference model.
module tb_rf_write_arbiter;

    logic        clk;
    logic        reset;
    logic        wb_we;
    logic [4:0]  wb_wa;
    logic [31:0] wb_wd;
    logic        md_valid;
    logic [4:0]  md_wa;
    logic [31:0] md_wd;
    logic        md_ready;
    logic        issue_valid;
    logic [4:0]  issue_wa;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [31:0] busy_mask;
    logic        wb_stall;

    int n_checks = 0;
    int n_fails  = 0;

    rf_write_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .wb_we       (wb_we),
        .wb_wa       (wb_wa),
        .wb_wd       (wb_wd),
        .md_valid    (md_valid),
        .md_wa       (md_wa),
        .md_wd       (md_wd),
        .md_ready    (md_ready),
        .issue_valid (issue_valid),
        .issue_wa    (issue_wa),
        .rf_we       (rf_we),
        .rf_wa       (rf_wa),
        .rf_wd       (rf_wd),
        .busy_mask   (busy_mask),
        .wb_stall    (wb_stall)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wb_we;
        logic [4:0]  wb_wa;
        logic [31:0] wb_wd;
        logic        md_valid;
        logic [4:0]  md_wa;
        logic [31:0] md_wd;
        logic        issue_valid;
        logic [4:0]  issue_wa;
        logic        exp_we;
        logic [4:0]  exp_wa;
        logic [31:0] exp_wd;
        logic        exp_ready;
        logic        exp_stall;
        logic [31:0] exp_busy;
    } vec_t;

    typedef struct {
        logic [4:0]  wa;
        logic [31:0] wd;
    } ent_t;

    localparam int NVEC = 26;
    vec_t vecs[NVEC];

    ent_t        mq[$];
    logic [31:0] m_busy;
    int          m_denials;

    function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic mv, input logic [4:0] mwa, input logic [31:0] mwd,
                                input logic iv, input logic [4:0] iwa,
                                input logic ewe, input logic [4:0] ewa, input logic [31:0] ewd,
                                input logic erdy, input logic estall, input logic [31:0] ebusy);
        vec_t v;
        v.wb_we = we;   v.wb_wa = wa;   v.wb_wd = wd;
        v.md_valid = mv; v.md_wa = mwa; v.md_wd = mwd;
        v.issue_valid = iv; v.issue_wa = iwa;
        v.exp_we = ewe; v.exp_wa = ewa; v.exp_wd = ewd;
        v.exp_ready = erdy; v.exp_stall = estall; v.exp_busy = ebusy;
        return v;
    endfunction

    task automatic applyStimulus(input logic r, input logic we, input logic [4:0] wa,
                                 input logic [31:0] wd, input logic mv, input logic [4:0] mwa,
                                 input logic [31:0] mwd, input logic iv, input logic [4:0] iwa);
        reset       = r;
        wb_we       = we;
        wb_wa       = wa;
        wb_wd       = wd;
        md_valid    = mv;
        md_wa       = mwa;
        md_wd       = mwd;
        issue_valid = iv;
        issue_wa    = iwa;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Compare every output against one expected set; called at the falling edge.
    task automatic checkAll(input string tag, input logic ewe, input logic [4:0] ewa,
                            input logic [31:0] ewd, input logic erdy, input logic estall,
                            input logic [31:0] ebusy);
        checkOutput({tag, ".rf_we"},     32'(rf_we),    32'(ewe));
        checkOutput({tag, ".rf_wa"},     32'(rf_wa),    32'(ewa));
        checkOutput({tag, ".rf_wd"},     rf_wd,         ewd);
        checkOutput({tag, ".md_ready"},  32'(md_ready), 32'(erdy));
        checkOutput({tag, ".wb_stall"},  32'(wb_stall), 32'(estall));
        checkOutput({tag, ".busy_mask"}, busy_mask,     ebusy);
    endtask

    // One cycle against the reference model: predict, check at negedge, advance at posedge.
    task automatic driveCycle(input string tag, input logic r, input logic we, input logic [4:0] wa,
                              input logic [31:0] wd, input logic mv, input logic [4:0] mwa,
                              input logic [31:0] mwd, input logic iv, input logic [4:0] iwa);
        logic        wbg;
        logic        hpop;
        logic        ewe;
        logic [4:0]  ewa;
        logic [31:0] ewd;
        logic        accept;
        applyStimulus(r, we, wa, wd, mv, mwa, mwd, iv, iwa);
        wbg  = !r && we && (wa != 5'd0);
        hpop = !r && !wbg && (mq.size() > 0);
        ewe = 1'b0; ewa = 5'd0; ewd = 32'd0;
        if (wbg) begin
            ewe = 1'b1; ewa = wa; ewd = wd;
        end else if (hpop && (mq[0].wa != 5'd0)) begin
            ewe = 1'b1; ewa = mq[0].wa; ewd = mq[0].wd;
        end
        @(negedge clk);
        checkAll(tag, ewe, ewa, ewd, mq.size() < 2, m_denials >= 3, m_busy);
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_busy    = 32'd0;
            m_denials = 0;
        end else begin
            accept = mv && (mq.size() < 2);
            if (hpop) begin
                m_busy[mq[0].wa] = 1'b0;
                void'(mq.pop_front());
                m_denials = 0;
            end else if ((mq.size() > 0) && (m_denials < 3)) begin
                m_denials++;
            end
            if (iv && (iwa != 5'd0)) m_busy[iwa] = 1'b1;
            if (accept) mq.push_back('{wa: mwa, wd: mwd});
            m_busy[0] = 1'b0;
        end
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        @(posedge clk);
        #1;
        mq.delete();
        m_busy    = 32'd0;
        m_denials = 0;
    endtask

    initial begin
        // Directed table; expectations worked out by hand from the arbitration rules.
        //            wb_we wa    wd            mv  mwa   mwd           iv  iwa     we  wa    wd            rdy stall busy
        vecs[0]  = mk(1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 32'h0,      1'b1, 5'd5,  1'b0, 5'd0, 32'h0,      1'b1, 1'b0, 32'h0);
        vecs[1]  = mk(1'b0, 5'd0, 32'h0,       1'b1, 5'd5, 32'h1234,   1'b1, 5'd6,  1'b0, 5'd0, 32'h0,      1'b1, 1'b0, 32'h20);
        vecs[2]  = mk(1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 32'h0,      1'b0, 5'd0,  1'b1, 5'd5, 32'h1234,   1'b1, 1'b0, 32'h60);
        vecs[3]  = mk(1'b1, 5'd7, 32'hAAAA,    1'b1, 5'd6, 32'h66,     1'b0, 5'd0,  1'b1, 5'd7, 32'hAAAA,   1'b1, 1'b0, 32'h40);
        vecs[4]  = mk(1'b1, 5'd7, 32'hBBBB,    1'b0, 5'd0, 32'h0,      1'b0, 5'd0,  1'b1, 5'd7, 32'hBBBB,   1'b1, 1'b0, 32'h40);
        vecs[5]  = mk(1'b1, 5'd7, 32'hCCCC,    1'b0, 5'd0, 32'h0,      1'b0, 5'd0,  1'b1, 5'd7, 32'hCCCC,   1'b1, 1'b0, 32'h40);
        vecs[6]  = mk(1'b1, 5'd7, 32'hDDDD,    1'b0, 5'd0, 32'h0,      1'b0, 5'd0,  1'b1, 5'd7, 32'hDDDD,   1'b1, 1'b0, 32'h40);
        vecs[7]  = mk(1'b1, 5'd7, 32'hEEEE,    1'b0, 5'd0, 32'h0,      1'b0, 5'd0,  1'b1, 5'd7, 32'hEEEE,   1'b1, 1'b1, 32'h40);
        vecs[8]  = mk(1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 32'h0,      1'b0, 5'd0,  1'b1, 5'd6, 32'h66,     1'b1, 1'b1, 32'h40);
        vecs[9]  = mk(1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 32'h0,      1'b0, 5'd0,  1'b0, 5'd0, 32'h0,      1'b1, 1'b0, 32'h0);
        vecs[10] = mk(1'b1, 5'd1, 32'h11,      1'b1, 5'd2, 32'h22,     1'b0, 5'd0,  1'b1, 5'd1, 32'h11,     1'b1, 1'b0, 32'h0);
        vecs[11] = mk(1'b1, 5'd1, 32'h12,      1'b1, 5'd3, 32'h33,     1'b0, 5'd0,  1'b1, 5'd1, 32'h12,     1'b1, 1'b0, 32'h0);
        vecs[12] = mk(1'b1, 5'd1, 32'h13,      1'b1, 5'd4, 32'h44,     1'b0, 5'd0,  1'b1, 5'd1, 32'h13,     1'b0, 1'b0, 32'h0);
        vecs[13] = mk(1'b1, 5'd1, 32'h14,      1'b1, 5'd4, 32'h44,     1'b0, 5'd0,  1'b1, 5'd1, 32'h14,     1'b0, 1'b0, 32'h0);
        vecs[14] = mk(1'b0, 5'd0, 32'h0,       1'b1, 5'd4, 32'h44,     1'b0, 5'd0,  1'b1, 5'd2, 32'h22,     1'b0, 1'b1, 32'h0);
        vecs[15] = mk(1'b0, 5'd0, 32'h0,       1'b1, 5'd4, 32'h44,     1'b0, 5'd0,  1'b1, 5'd3, 32'h33,     1'b1, 1'b0, 32'h0);
        vecs[16] = mk(1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 32'h0,      1'b0, 5'd0,  1'b1, 5'd4, 32'h44,     1'b1, 1'b0, 32'h0);
        vecs[17] = mk(1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 32'h0,      1'b1, 5'd9,  1'b0, 5'd0, 32'h0,      1'b1, 1'b0, 32'h0);
        vecs[18] = mk(1'b0, 5'd0, 32'h0,       1'b1, 5'd9, 32'h99,     1'b0, 5'd0,  1'b0, 5'd0, 32'h0,      1'b1, 1'b0, 32'h200);
        vecs[19] = mk(1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 32'h0,      1'b1, 5'd9,  1'b1, 5'd9, 32'h99,     1'b1, 1'b0, 32'h200);
        vecs[20] = mk(1'b0, 5'd0, 32'h0,       1'b1, 5'd0, 32'hDEAD,   1'b0, 5'd0,  1'b0, 5'd0, 32'h0,      1'b1, 1'b0, 32'h200);
        vecs[21] = mk(1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 32'h0,      1'b0, 5'd0,  1'b0, 5'd0, 32'h0,      1'b1, 1'b0, 32'h200);
        vecs[22] = mk(1'b0, 5'd0, 32'h0,       1'b1, 5'd8, 32'h88,     1'b0, 5'd0,  1'b0, 5'd0, 32'h0,      1'b1, 1'b0, 32'h200);
        vecs[23] = mk(1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 32'h0,      1'b1, 5'd0,  1'b1, 5'd8, 32'h88,     1'b1, 1'b0, 32'h200);
        vecs[24] = mk(1'b0, 5'd0, 32'h0,       1'b1, 5'd3, 32'h30,     1'b0, 5'd0,  1'b0, 5'd0, 32'h0,      1'b1, 1'b0, 32'h200);
        vecs[25] = mk(1'b1, 5'd0, 32'hFFFF,    1'b0, 5'd0, 32'h0,      1'b0, 5'd0,  1'b1, 5'd3, 32'h30,     1'b1, 1'b0, 32'h200);

        // Initial reset and reset-state check.
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        @(negedge clk);
        checkAll("reset_state", 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 32'd0);
        @(posedge clk);
        #1;

        // Directed vector table.
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(1'b0, vecs[i].wb_we, vecs[i].wb_wa, vecs[i].wb_wd,
                          vecs[i].md_valid, vecs[i].md_wa, vecs[i].md_wd,
                          vecs[i].issue_valid, vecs[i].issue_wa);
            @(negedge clk);
            checkAll($sformatf("vec%0d", i), vecs[i].exp_we, vecs[i].exp_wa, vecs[i].exp_wd,
                     vecs[i].exp_ready, vecs[i].exp_stall, vecs[i].exp_busy);
            @(posedge clk);
            #1;
        end

        // Reset with the FIFO full: discarded entries must never reach the port.
        doReset();
        driveCycle("fill0", 1'b0, 1'b1, 5'd1, 32'h100, 1'b1, 5'd10, 32'hA0, 1'b1, 5'd10);
        driveCycle("fill1", 1'b0, 1'b1, 5'd1, 32'h101, 1'b1, 5'd11, 32'hA1, 1'b1, 5'd11);
        driveCycle("fill2", 1'b0, 1'b1, 5'd1, 32'h102, 1'b1, 5'd12, 32'hA2, 1'b0, 5'd0);
        checkOutput("full_ready_low", 32'(md_ready), 32'd0);
        driveCycle("rst_full", 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hA2, 1'b1, 5'd13);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        @(negedge clk);
        checkAll("post_reset", 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        driveCycle("post_reset2", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);

        // Randomized traffic checked against the queue model.
        for (int c = 0; c < 3000; c++) begin
            logic        r;
            logic        we;
            logic [4:0]  wa;
            logic        mv;
            logic        iv;
            r  = ($urandom_range(0, 299) == 0);
            we = ($urandom_range(0, 9) < 7);
            wa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            mv = ($urandom_range(0, 1) == 1);
            iv = ($urandom_range(0, 9) < 3);
            driveCycle($sformatf("rand%0d", c), r, we, wa, $urandom,
                       mv, 5'($urandom_range(0, 15)), $urandom,
                       iv, 5'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL: wb_we, wb_wa, wb_wd  input  1/5/32  pipeline writeback request (no backpressure).
REQ-004 SHALL: md_valid, md_wa, md_wd  input  1/5/32  multicycle (mul/div) result offer.
REQ-005 SHALL: md_ready  output  1  result FIFO can accept; transfer when md_valid && md_ready.
REQ-006 SHALL: issue_valid, issue_wa  input  1/5  multicycle op issued, destination register.
REQ-007 SHALL: rf_we, rf_wa, rf_wd  output  1/5/32  single register-file write port (we3/wa3/wd3).
REQ-008 SHALL: busy_mask  output  32  scoreboard, bit n = result for rn still pending.
REQ-009 SHALL: wb_stall  output  1  request to hazard unit: bubble WB next cycle.

Function
REQ-010 SHALL: md results buffer in a 2-entry FIFO; md_ready = !full, registered-state only (no combinational path from md_valid).
REQ-011 SHALL: grant priority: WB request (wb_we && wb_wa!=0) wins; else FIFO head, if non-empty, is written and popped.
REQ-012 SHALL: rf_* driven combinationally from the granted source in the same cycle; rf_we=0, rf_wa=0, rf_wd=0 when no grant.
REQ-013 SHALL: writes addressed to r0 from either source never assert rf_we; an r0 FIFO entry is popped without writing.
REQ-014 SHALL: latency md accept at cycle t -> earliest rf_we for it at t+1; FIFO order preserved.
REQ-015 SHALL: simultaneous push and pop in one cycle allowed at any occupancy, including full (occupancy unchanged).
REQ-016 SHALL: FSM states IDLE (FIFO empty), PEND (head waiting), STARVE (wb_stall=1).
REQ-017 SHALL: IDLE->PEND on push; PEND->IDLE when last entry pops with no push; PEND->STARVE when head denied 3 consecutive cycles; STARVE->PEND when head pops and FIFO stays non-empty, STARVE->IDLE when it empties.
REQ-018 SHALL: wait counter (2 bits, saturating at 3) counts consecutive denied cycles of the current head; cleared on every pop.
REQ-019 SHALL: wb_stall = (state==STARVE); if WB still writes during STARVE, WB wins, no data lost, state held.
REQ-020 SHALL: issue_valid with issue_wa!=0 sets busy_mask[issue_wa] next cycle; bit 0 always 0.
REQ-021 SHALL: a FIFO-sourced pop (including the r0 case) clears busy_mask[head wa] next cycle; WB writes never clear bits.
REQ-022 SHALL: set and clear of the same bit in one cycle -> bit ends set.

Reset
REQ-023 SHALL: reset empties FIFO, state=IDLE, counter=0, busy_mask=0, wb_stall=0, md_ready=1 next cycle.
REQ-024 SHALL: reset mid-operation discards buffered results without writing them; reset has priority over all inputs in that cycle.

Structure
REQ-025 SHALL: package rf_pkg holds REG_AW=5, DATA_W=32, MD_FIFO_DEPTH=2, STARVE_LIMIT=3, arbiter state enum.
REQ-026 SHALL: FIFO is sub-module md_result_fifo (push/pop/full/empty, head wa/wd); arbiter, FSM, scoreboard stay in top.

Verification
REQ-027 SHALL: md push r5=0x1234 with wb_we=0 -> next cycle rf_we=1, rf_wa=5, rf_wd=0x1234, busy_mask[5] cleared.
REQ-028 SHALL: md push r6 while wb_we=1 to r7 for 3 cycles -> wb_stall=1 in cycle 4; WB idle -> r6 written, state PEND/IDLE.
REQ-029 SHALL: two pushes with continuous WB writes -> md_ready=0; third md_valid held, accepted only after a pop.
REQ-030 SHALL: issue r9 and pop r9 in same cycle -> busy_mask[9]=1; md result to r0 -> no rf_we, FIFO popped.
REQ-031 SHALL: reset asserted with FIFO full -> next cycle empty, busy_mask=0, md_ready=1, no rf_we for discarded entries.
